// File: rtl/i2c_responder_pkg.sv
// Shared FSM state type and bus constants for the I2C register responder.
package i2c_responder_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_DEV,
    ST_DEV_ACK,
    ST_SUB,
    ST_SUB_ACK,
    ST_WDATA,
    ST_WACK,
    ST_RDATA,
    ST_RACK,
    ST_IGNORE
  } state_t;

  localparam logic       I2C_ACK  = 1'b0;
  localparam logic       I2C_NACK = 1'b1;
  localparam logic [7:0] REG_RST  = 8'h00;

endpackage

// File: rtl/i2c_bus_sync.sv
// SCL/SDA synchronizers with SCL edge and START/STOP pulse generation.
module i2c_bus_sync (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [1:0] r_scl_sync;
  logic [1:0] r_sda_sync;
  logic       r_scl_q;
  logic       r_sda_q;
  logic       w_scl;
  logic       w_sda;

  // An idle bus is high on both lines, so reset to 1 to avoid false edges.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
      r_scl_q    <= 1'b1;
      r_sda_q    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[0], i_scl};
      r_sda_sync <= {r_sda_sync[0], i_sda};
      r_scl_q    <= r_scl_sync[1];
      r_sda_q    <= r_sda_sync[1];
    end
  end

  assign w_scl      = r_scl_sync[1];
  assign w_sda      = r_sda_sync[1];
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_q;
  assign o_scl_fall = ~w_scl & r_scl_q;
  assign o_start    = w_scl & r_scl_q & ~w_sda & r_sda_q;
  assign o_stop     = w_scl & r_scl_q & w_sda & ~r_sda_q;

endmodule

// File: rtl/i2c_reg_responder.sv
// I2C target with a 256x8 register file and a host read port.
// Define I2C_RESPONDER_READ_EN to compile in the bus read path.
module i2c_reg_responder #(
  parameter logic [6:0]  DEV_ADDR = 7'h39,
  parameter int unsigned CLK_Freq = 50000000
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       I2C_SCLK,
  inout  wire        I2C_SDAT,
  input  logic [7:0] iREG_ADDR,
  output logic [7:0] oREG_DATA,
  output logic       oWR_STB,
  output logic [7:0] oWR_ADDR,
  output logic [7:0] oWR_DATA,
  output logic       oBUSY
);

  import i2c_responder_pkg::*;

  state_t     r_state;
  logic [2:0] r_bitcnt;
  logic [6:0] r_shift;
  logic [7:0] r_ptr;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_wr_stb;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_reg_data;
  logic [7:0] r_regs [256];
`ifdef I2C_RESPONDER_READ_EN
  logic       r_rw;
  logic       r_mack;
`endif

  logic       w_sda;
  logic       w_rise;
  logic       w_fall;
  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_last;
  logic       w_match;

  i2c_bus_sync u_sync (
    .i_clk      (iCLK),
    .i_rst_n    (iRST_N),
    .i_scl      (I2C_SCLK),
    .i_sda      (I2C_SDAT),
    .o_sda      (w_sda),
    .o_scl_rise (w_rise),
    .o_scl_fall (w_fall),
    .o_start    (w_start),
    .o_stop     (w_stop)
  );

  assign w_byte  = {r_shift, w_sda};
  assign w_last  = (r_bitcnt == 3'd7);
  assign w_match = (r_shift == DEV_ADDR);

  assert property (@(posedge iCLK) CLK_Freq >= 320000);

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      r_state    <= ST_IDLE;
      r_bitcnt   <= '0;
      r_shift    <= '0;
      r_ptr      <= '0;
      r_sda_oe   <= 1'b0;
      r_busy     <= 1'b0;
      r_wr_stb   <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_reg_data <= REG_RST;
      for (int i = 0; i < 256; i++) r_regs[i] <= REG_RST;
`ifdef I2C_RESPONDER_READ_EN
      r_rw       <= 1'b0;
      r_mack     <= 1'b0;
`endif
    end else begin
      r_wr_stb   <= 1'b0;
      r_reg_data <= r_regs[iREG_ADDR];
      if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_start) begin
        r_state  <= ST_DEV;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
      end else begin
        case (r_state)
          ST_DEV: if (w_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              if (!w_match) begin
                r_state <= ST_IGNORE;
`ifdef I2C_RESPONDER_READ_EN
              end else begin
                r_rw    <= w_sda;
                r_busy  <= 1'b1;
                r_state <= ST_DEV_ACK;
              end
`else
              end else if (w_sda) begin
                r_state <= ST_IGNORE;
              end else begin
                r_busy  <= 1'b1;
                r_state <= ST_DEV_ACK;
              end
`endif
            end
          end
          // First fall after the byte starts the ACK, the next one ends it.
          ST_DEV_ACK, ST_SUB_ACK, ST_WACK: if (w_fall) begin
            if (!r_sda_oe) begin
              r_sda_oe <= 1'b1;
            end else begin
              r_sda_oe <= 1'b0;
              r_bitcnt <= '0;
              r_state  <= (r_state == ST_DEV_ACK) ? ST_SUB : ST_WDATA;
`ifdef I2C_RESPONDER_READ_EN
              if (r_state == ST_DEV_ACK && r_rw) begin
                r_shift  <= r_regs[r_ptr][6:0];
                r_sda_oe <= ~r_regs[r_ptr][7];
                r_state  <= ST_RDATA;
              end
`endif
            end
          end
          ST_SUB: if (w_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              r_ptr   <= w_byte;
              r_state <= ST_SUB_ACK;
            end
          end
          ST_WDATA: if (w_rise) begin
            r_shift  <= w_byte[6:0];
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              r_regs[r_ptr] <= w_byte;
              r_wr_stb      <= 1'b1;
              r_wr_addr     <= r_ptr;
              r_wr_data     <= w_byte;
              r_ptr         <= r_ptr + 8'd1;
              r_state       <= ST_WACK;
            end
          end
`ifdef I2C_RESPONDER_READ_EN
          ST_RDATA: begin
            if (w_rise) begin
              r_bitcnt <= r_bitcnt + 3'd1;
              if (w_last) begin
                r_ptr   <= r_ptr + 8'd1;
                r_mack  <= 1'b0;
                r_state <= ST_RACK;
              end
            end else if (w_fall) begin
              r_shift  <= {r_shift[5:0], 1'b0};
              r_sda_oe <= ~r_shift[6];
            end
          end
          ST_RACK: begin
            if (w_rise) begin
              if (w_sda == I2C_NACK) r_state <= ST_IGNORE;
              else r_mack <= 1'b1;
            end else if (w_fall) begin
              r_sda_oe <= 1'b0;
              if (r_mack) begin
                r_shift  <= r_regs[r_ptr][6:0];
                r_sda_oe <= ~r_regs[r_ptr][7];
                r_bitcnt <= '0;
                r_state  <= ST_RDATA;
              end
            end
          end
`endif
          default: r_sda_oe <= 1'b0;
        endcase
      end
    end
  end

  assign I2C_SDAT  = r_sda_oe ? 1'b0 : 1'bz;
  assign oREG_DATA = r_reg_data;
  assign oWR_STB   = r_wr_stb;
  assign oWR_ADDR  = r_wr_addr;
  assign oWR_DATA  = r_wr_data;
  assign oBUSY     = r_busy;

endmodule

// File: tb/tb_i2c_reg_responder.sv
// Bench for i2c_reg_responder: bus master model plus register-file reference.
`timescale 1ns/1ps
module tb_i2c_reg_responder;

  localparam int Q = 8;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       scl = 1'b1;
  logic       m_low = 1'b0;
  logic [7:0] reg_addr = 8'h00;
  wire        sda;
  logic [7:0] reg_data;
  logic       wr_stb;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       busy;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mem [256];
  wr_t        stb_q[$];
  wr_t        exp_q[$];
  logic       drove = 1'b0;
  logic       busy_seen = 1'b0;
  logic       hit_pend = 1'b0;
  logic [7:0] hit_old = 8'h00;
  logic [7:0] hit_new = 8'h00;

  assign sda = m_low ? 1'b0 : 1'bz;
  pullup (sda);

  always #5 clk = ~clk;

  i2c_reg_responder dut (
    .iCLK      (clk),
    .iRST_N    (rst_n),
    .I2C_SCLK  (scl),
    .I2C_SDAT  (sda),
    .iREG_ADDR (reg_addr),
    .oREG_DATA (reg_data),
    .oWR_STB   (wr_stb),
    .oWR_ADDR  (wr_addr),
    .oWR_DATA  (wr_data),
    .oBUSY     (busy)
  );

  always @(negedge clk) begin
    #2;
    if (hit_pend) begin
      hit_new  = reg_data;
      hit_pend = 1'b0;
    end
    if (wr_stb) begin
      stb_q.push_back({wr_addr, wr_data});
      if (wr_addr == reg_addr) begin
        hit_old  = reg_data;
        hit_pend = 1'b1;
      end
    end
    if (!m_low && sda === 1'b0) drove = 1'b1;
    if (busy) busy_seen = 1'b1;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    m_low = ~b;
    tick(Q); scl = 1'b1; tick(2 * Q); scl = 1'b0; tick(Q);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    m_low = 1'b0;
    tick(Q); scl = 1'b1; tick(Q); ack = sda; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] b);
    m_low = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      tick(Q); scl = 1'b1; tick(Q); b[i] = sda; tick(Q); scl = 1'b0; tick(Q);
    end
    m_low = ~mack;
    tick(Q); scl = 1'b1; tick(2 * Q); scl = 1'b0; m_low = 1'b0; tick(Q);
  endtask

  task automatic i2c_start();
    m_low = 1'b0; tick(Q); scl = 1'b1; tick(Q);
    m_low = 1'b1; tick(Q); scl = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop();
    m_low = 1'b1; tick(Q); scl = 1'b1; tick(Q); m_low = 1'b0; tick(Q);
  endtask

  task automatic i2c_write(input logic [7:0] dev, input logic [7:0] sub,
                           input logic [31:0] d, input int n,
                           output logic [5:0] acks, output logic bmid);
    logic a;
    acks = '1;
    i2c_start();
    send_byte(dev, a); acks[0] = a;
    send_byte(sub, a); acks[1] = a;
    for (int i = 0; i < n; i++) begin
      send_byte(d[31-8*i -: 8], a);
      acks[2+i] = a;
    end
    bmid = busy;
    i2c_stop();
  endtask

  task automatic model_write(input logic [7:0] sub, input logic [31:0] d, input int n);
    logic [7:0] p;
    p = sub;
    for (int i = 0; i < n; i++) begin
      mem[p] = d[31-8*i -: 8];
      exp_q.push_back({p, d[31-8*i -: 8]});
      p = p + 8'd1;
    end
  endtask

  task automatic read_reg(input logic [7:0] a, output logic [7:0] d);
    reg_addr = a;
    tick(1);
    d = reg_data;
  endtask

  task automatic test_reset();
    logic [7:0] d;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    rst_n = 1'b0; tick(4); rst_n = 1'b1; tick(2);
    n_cmp++; if (reg_data !== 8'h00) begin n_bad++; $display("FAIL reset_reg_data: got %h want 00", reg_data); end
    n_cmp++; if (wr_stb !== 1'b0) begin n_bad++; $display("FAIL reset_wr_stb: got %b want 0", wr_stb); end
    n_cmp++; if (wr_addr !== 8'h00) begin n_bad++; $display("FAIL reset_wr_addr: got %h want 00", wr_addr); end
    n_cmp++; if (wr_data !== 8'h00) begin n_bad++; $display("FAIL reset_wr_data: got %h want 00", wr_data); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL reset_sda: got %b want released", sda); end
    read_reg(8'h98, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL reset_regs: got %h want 00", d); end
  endtask

  task automatic test_write_frame();
    logic [5:0] acks;
    logic bmid;
    logic [7:0] d;
    stb_q.delete(); exp_q.delete();
    i2c_write(8'h72, 8'h98, 32'h0300_0000, 1, acks, bmid);
    model_write(8'h98, 32'h0300_0000, 1);
    tick(2);
    n_cmp++; if (acks[2:0] !== 3'b000) begin n_bad++; $display("FAIL write_acks: got %b want 000", acks[2:0]); end
    n_cmp++; if (bmid !== 1'b1) begin n_bad++; $display("FAIL write_busy_mid: got %b want 1", bmid); end
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL write_busy_after_stop: got %b want 0", busy); end
    n_cmp++;
    if (stb_q.size() != 1 || stb_q[0] !== {8'h98, 8'h03}) begin
      n_bad++;
      $display("FAIL write_strobe: got %0d strobes first %h want 1 strobe 9803", stb_q.size(), stb_q[0]);
    end
    read_reg(8'h98, d);
    n_cmp++; if (d !== 8'h03) begin n_bad++; $display("FAIL write_reg98: got %h want 03", d); end
  endtask

  task automatic test_wrong_addr();
    logic [5:0] acks;
    logic bmid;
    logic [7:0] d;
    stb_q.delete(); exp_q.delete();
    drove = 1'b0; busy_seen = 1'b0;
    i2c_write(8'h74, 8'h15, 32'h2000_0000, 1, acks, bmid);
    tick(2);
    n_cmp++; if (acks[2:0] !== 3'b111) begin n_bad++; $display("FAIL wrongaddr_acks: got %b want 111", acks[2:0]); end
    n_cmp++; if (drove !== 1'b0) begin n_bad++; $display("FAIL wrongaddr_sda_driven: got %b want 0", drove); end
    n_cmp++; if (busy_seen !== 1'b0) begin n_bad++; $display("FAIL wrongaddr_busy: got %b want 0", busy_seen); end
    n_cmp++; if (stb_q.size() != 0) begin n_bad++; $display("FAIL wrongaddr_strobes: got %0d want 0", stb_q.size()); end
    read_reg(8'h15, d);
    n_cmp++; if (d !== mem[8'h15]) begin n_bad++; $display("FAIL wrongaddr_reg15: got %h want %h", d, mem[8'h15]); end
  endtask

  task automatic test_wrap();
    logic [5:0] acks;
    logic bmid;
    logic [7:0] d;
    stb_q.delete(); exp_q.delete();
    i2c_write(8'h72, 8'hFF, 32'h1122_0000, 2, acks, bmid);
    model_write(8'hFF, 32'h1122_0000, 2);
    tick(2);
    n_cmp++; if (acks[3:0] !== 4'b0000) begin n_bad++; $display("FAIL wrap_acks: got %b want 0000", acks[3:0]); end
    read_reg(8'hFF, d);
    n_cmp++; if (d !== 8'h11) begin n_bad++; $display("FAIL wrap_regFF: got %h want 11", d); end
    read_reg(8'h00, d);
    n_cmp++; if (d !== 8'h22) begin n_bad++; $display("FAIL wrap_reg00: got %h want 22", d); end
    n_cmp++; if (stb_q.size() != 2) begin n_bad++; $display("FAIL wrap_strobe_count: got %0d want 2", stb_q.size()); end
    for (int i = 0; i < 2 && i < stb_q.size(); i++) begin
      n_cmp++;
      if (stb_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL wrap_strobe%0d: got %h want %h", i, stb_q[i], exp_q[i]); end
    end
  endtask

  task automatic test_read();
    logic [5:0] acks;
    logic bmid;
    logic a;
    stb_q.delete(); exp_q.delete();
    i2c_write(8'h72, 8'h15, 32'hABCD_0000, 2, acks, bmid);
    model_write(8'h15, 32'hABCD_0000, 2);
    i2c_start();
    send_byte(8'h72, a);
    send_byte(8'h15, a);
    i2c_start();
    drove = 1'b0;
    send_byte(8'h73, a);
`ifdef I2C_RESPONDER_READ_EN
    begin
      logic [7:0] b0, b1;
      n_cmp++; if (a !== 1'b0) begin n_bad++; $display("FAIL read_dev_ack: got %b want 0", a); end
      recv_byte(1'b0, b0);
      recv_byte(1'b1, b1);
      n_cmp++; if (b0 !== mem[8'h15]) begin n_bad++; $display("FAIL read_byte0: got %h want %h", b0, mem[8'h15]); end
      n_cmp++; if (b1 !== mem[8'h16]) begin n_bad++; $display("FAIL read_byte1: got %h want %h", b1, mem[8'h16]); end
      n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL read_busy_ignore: got %b want 1", busy); end
    end
`else
    n_cmp++; if (a !== 1'b1) begin n_bad++; $display("FAIL read_disabled_nack: got %b want 1", a); end
    n_cmp++; if (drove !== 1'b0) begin n_bad++; $display("FAIL read_disabled_sda: got %b want 0", drove); end
`endif
    i2c_stop();
    n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL read_busy_stop: got %b want 0", busy); end
  endtask

  task automatic test_partial();
    logic [5:0] acks;
    logic bmid;
    logic a;
    logic [7:0] d;
    stb_q.delete(); exp_q.delete();
    i2c_start();
    send_byte(8'h72, a);
    send_byte(8'h40, a);
    for (int i = 0; i < 4; i++) send_bit(i[0]);
    i2c_stop();
    i2c_write(8'h72, 8'h16, 32'h5C00_0000, 1, acks, bmid);
    model_write(8'h16, 32'h5C00_0000, 1);
    tick(2);
    n_cmp++;
    if (stb_q.size() != 1 || stb_q[0] !== {8'h16, 8'h5C}) begin
      n_bad++;
      $display("FAIL partial_strobe: got %0d strobes first %h want 1 strobe 165c", stb_q.size(), stb_q[0]);
    end
    read_reg(8'h40, d);
    n_cmp++; if (d !== mem[8'h40]) begin n_bad++; $display("FAIL partial_reg40: got %h want %h", d, mem[8'h40]); end
    read_reg(8'h16, d);
    n_cmp++; if (d !== 8'h5C) begin n_bad++; $display("FAIL partial_reg16: got %h want 5c", d); end
  endtask

  task automatic test_same_cycle();
    logic [5:0] acks;
    logic bmid;
    logic [7:0] old;
    old = mem[8'h40];
    reg_addr = 8'h40;
    hit_old = 8'hEE; hit_new = 8'hEE;
    tick(2);
    i2c_write(8'h72, 8'h40, 32'h5A00_0000, 1, acks, bmid);
    model_write(8'h40, 32'h5A00_0000, 1);
    tick(2);
    n_cmp++; if (hit_old !== old) begin n_bad++; $display("FAIL samecycle_old: got %h want %h", hit_old, old); end
    n_cmp++; if (hit_new !== 8'h5A) begin n_bad++; $display("FAIL samecycle_new: got %h want 5a", hit_new); end
  endtask

  task automatic test_random();
    logic [5:0] acks;
    logic bmid;
    logic [7:0] sub, d;
    logic [31:0] data;
    int n;
    stb_q.delete(); exp_q.delete();
    for (int f = 0; f < 6; f++) begin
      sub  = 8'($urandom_range(0, 255));
      n    = $urandom_range(1, 3);
      data = $urandom;
      i2c_write(8'h72, sub, data, n, acks, bmid);
      model_write(sub, data, n);
      n_cmp++;
      if ((acks & ((6'd1 << (n + 2)) - 6'd1)) !== 6'd0) begin
        n_bad++; $display("FAIL random_acks%0d: got %b want all zero", f, acks);
      end
    end
    tick(2);
    n_cmp++;
    if (stb_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL random_strobe_count: got %0d want %0d", stb_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < stb_q.size(); i++) begin
      n_cmp++;
      if (stb_q[i] !== exp_q[i]) begin n_bad++; $display("FAIL random_strobe%0d: got %h want %h", i, stb_q[i], exp_q[i]); end
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      read_reg(exp_q[i].a, d);
      n_cmp++;
      if (d !== mem[exp_q[i].a]) begin n_bad++; $display("FAIL random_reg%h: got %h want %h", exp_q[i].a, d, mem[exp_q[i].a]); end
    end
  endtask

  task automatic test_reset_mid_ack();
    logic [5:0] acks;
    logic bmid;
    logic [7:0] d;
    i2c_start();
    for (int i = 7; i >= 0; i--) send_bit(i != 0 && ((8'h72 >> i) & 1) == 1);
    m_low = 1'b0;
    tick(2);
    n_cmp++; if (sda !== 1'b0) begin n_bad++; $display("FAIL rstack_driving: got %b want 0", sda); end
    #1 rst_n = 1'b0;
    #1;
    n_cmp++; if (sda !== 1'b1) begin n_bad++; $display("FAIL rstack_release: got %b want released", sda); end
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    tick(3); rst_n = 1'b1;
    tick(Q); scl = 1'b1; tick(Q);
    read_reg(8'h98, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstack_reg98: got %h want 00", d); end
    read_reg(8'hFF, d);
    n_cmp++; if (d !== 8'h00) begin n_bad++; $display("FAIL rstack_regFF: got %h want 00", d); end
    i2c_write(8'h72, 8'h20, 32'h7700_0000, 1, acks, bmid);
    model_write(8'h20, 32'h7700_0000, 1);
    n_cmp++; if (acks[2:0] !== 3'b000) begin n_bad++; $display("FAIL rstack_next_acks: got %b want 000", acks[2:0]); end
    read_reg(8'h20, d);
    n_cmp++; if (d !== mem[8'h20]) begin n_bad++; $display("FAIL rstack_next_reg: got %h want %h", d, mem[8'h20]); end
  endtask

  initial begin
    test_reset();
    test_write_frame();
    test_wrong_addr();
    test_wrap();
    test_read();
    test_partial();
    test_same_cycle();
    test_random();
    test_reset_mid_ack();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
